// File: rtl/oto_pilot_pkg.sv
// Shared types for the altitude-hold controller: FSM states and komut_o encodings.
package oto_pilot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [2:0] KOMUT_TIRMAN = 3'b001;
  localparam logic [2:0] KOMUT_SABIT  = 3'b010;
  localparam logic [2:0] KOMUT_ALCAL  = 3'b100;
  localparam logic [2:0] KOMUT_YOK    = 3'b000;

endpackage

// File: rtl/irtifa_birlestir.sv
// GNSS/altimeter fusion with disagreement flag; optional 4-tap boxcar under OTO_PILOT_FILTER_EN.
// Latency 1 cycle (2 with the boxcar); no backpressure, one result per valid sample.
module irtifa_birlestir
  import oto_pilot_pkg::*;
#(
  parameter int ALT_W    = 10,
  parameter int MAX_DIFF = 8
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [ALT_W-1:0] gnss,
  input  logic [ALT_W-1:0] altimetre,
  input  logic             sample_vld,
`ifdef OTO_PILOT_FILTER_EN
  input  logic             clear,
`endif
  output logic [ALT_W-1:0] fused,
  output logic             fused_vld,
  output logic             sapma,
  output logic             sapma_vld
);

  localparam logic [ALT_W-1:0] MAX_D = ALT_W'(MAX_DIFF);

  logic [ALT_W-1:0] diff;
  logic             disagree;
  logic [ALT_W:0]   sum;
  logic [ALT_W-1:0] avg;
  logic [ALT_W-1:0] s1_alt;
  logic             s1_vld;

  always_comb begin
    diff     = (gnss >= altimetre) ? (gnss - altimetre) : (altimetre - gnss);
    disagree = (diff > MAX_D);
    // ALT_W+1 bit sum keeps 1023+1023+1 from wrapping
    sum      = {1'b0, gnss} + {1'b0, altimetre} + {{ALT_W{1'b0}}, 1'b1};
    avg      = ALT_W'(sum >> 1);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1_alt <= '0;
      s1_vld <= 1'b0;
      sapma  <= 1'b0;
    end else begin
      s1_vld <= sample_vld;
      if (sample_vld) begin
        s1_alt <= disagree ? altimetre : avg;
        sapma  <= disagree;
      end
    end
  end

  assign sapma_vld = s1_vld;

`ifdef OTO_PILOT_FILTER_EN
  logic [3:0][ALT_W-1:0] taps;
  logic [ALT_W+1:0]      acc;
  logic [ALT_W+1:0]      acc_next;
  logic                  first;
  logic [ALT_W-1:0]      box_out;
  logic                  box_vld;

  always_comb begin
    acc_next = first ? ({2'b00, s1_alt} << 2)
                     : (acc + {2'b00, s1_alt} - {2'b00, taps[3]});
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      taps    <= '0;
      acc     <= '0;
      first   <= 1'b1;
      box_out <= '0;
      box_vld <= 1'b0;
    end else if (clear) begin
      first   <= 1'b1;
      box_vld <= 1'b0;
    end else begin
      box_vld <= s1_vld;
      if (s1_vld) begin
        // first sample after a clear pre-fills every tap
        taps    <= first ? {4{s1_alt}} : {taps[2:0], s1_alt};
        acc     <= acc_next;
        first   <= 1'b0;
        box_out <= ALT_W'((acc_next + (ALT_W+2)'(2)) >> 2);
      end
    end
  end

  assign fused     = box_out;
  assign fused_vld = box_vld;
`else
  assign fused     = s1_alt;
  assign fused_vld = s1_vld;
`endif

endmodule

// File: rtl/irtifa_tutma_ctrl.sv
// Altitude-hold controller: FSM, target register, settle/disagreement/timeout counters (filter via OTO_PILOT_FILTER_EN).
// komut_o settles 2 cycles after the SETTLE-th equal decision (3 with filter); no backpressure.
module irtifa_tutma_ctrl
  import oto_pilot_pkg::*;
#(
  parameter int ALT_W    = 10,
  parameter int HYST     = 2,
  parameter int MAX_DIFF = 8,
  parameter int FAULT_N  = 8,
  parameter int SETTLE   = 4,
  parameter int SENS_TMO = 1000
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [ALT_W-1:0] gnss_i,
  input  logic [ALT_W-1:0] altimetre_i,
  input  logic             yukseklik_bilgisi_i,
  input  logic [ALT_W-1:0] hedef_yukseklik_i,
  input  logic             hedef_yukle_i,
  output logic [2:0]       komut_o,
  output logic [ALT_W-1:0] irtifa_o,
  output logic             sapma_o,
  output logic             hata_o
);

  localparam int SAP_W = $clog2(FAULT_N + 1);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMO_W = $clog2(SENS_TMO + 1);
  localparam logic [SAP_W-1:0]     SAP_MAX = SAP_W'(FAULT_N);
  localparam logic [SET_W-1:0]     SET_MAX = SET_W'(SETTLE);
  localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(SENS_TMO);
  localparam logic signed [ALT_W:0] HYST_S = (ALT_W+1)'(HYST);

  logic [ALT_W-1:0]  fused;
  logic              fused_vld;
  logic              sapma;
  logic              sapma_vld;
  state_t            state, state_nxt;
  logic [ALT_W-1:0]  target;
  logic [SET_W-1:0]  settle_cnt, settle_new;
  logic [SAP_W-1:0]  sapma_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [2:0]        son_karar, karar, komut_q;
  logic signed [ALT_W:0] err;

  irtifa_birlestir #(.ALT_W(ALT_W), .MAX_DIFF(MAX_DIFF)) u_birlestir (
    .clock      (clock),
    .resetb     (resetb),
    .gnss       (gnss_i),
    .altimetre  (altimetre_i),
    .sample_vld (yukseklik_bilgisi_i),
`ifdef OTO_PILOT_FILTER_EN
    .clear      (hedef_yukle_i),
`endif
    .fused      (fused),
    .fused_vld  (fused_vld),
    .sapma      (sapma),
    .sapma_vld  (sapma_vld)
  );

  assign irtifa_o = fused;
  assign sapma_o  = sapma;

  always_comb begin
    err   = $signed({1'b0, target}) - $signed({1'b0, fused});
    karar = KOMUT_SABIT;
    if (err > HYST_S)       karar = KOMUT_TIRMAN;
    else if (err < -HYST_S) karar = KOMUT_ALCAL;

    settle_new = settle_cnt;
    if (settle_cnt == '0 || karar != son_karar) settle_new = SET_W'(1);
    else if (settle_cnt != SET_MAX)             settle_new = settle_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    komut_o   = KOMUT_YOK;
    hata_o    = 1'b0;
    case (state)
      IDLE: if (hedef_yukle_i) state_nxt = RUN;
      RUN: begin
        komut_o = komut_q;
        // a load in the same cycle as a fault condition keeps us running
        if (!hedef_yukle_i && (sapma_cnt == SAP_MAX || tmo_cnt == TMO_MAX))
          state_nxt = FAULT;
      end
      FAULT: begin
        hata_o = 1'b1;
        if (hedef_yukle_i) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      target     <= '0;
      settle_cnt <= '0;
      sapma_cnt  <= '0;
      tmo_cnt    <= '0;
      son_karar  <= KOMUT_YOK;
      komut_q    <= KOMUT_YOK;
    end else begin
      if (hedef_yukle_i) begin
        target     <= hedef_yukseklik_i;
        settle_cnt <= '0;
        sapma_cnt  <= '0;
        tmo_cnt    <= '0;
      end else if (state == RUN) begin
        if (yukseklik_bilgisi_i)  tmo_cnt <= '0;
        else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
        if (sapma_vld) begin
          if (!sapma)                 sapma_cnt <= '0;
          else if (sapma_cnt != SAP_MAX) sapma_cnt <= sapma_cnt + 1'b1;
        end
        if (fused_vld) begin
          son_karar  <= karar;
          settle_cnt <= settle_new;
          if (settle_new == SET_MAX) komut_q <= karar;
        end
      end
      if (state != RUN) komut_q <= KOMUT_YOK;
    end
  end

endmodule
